// File: rtl/accumulator_control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit accumulator machine.
// Owns PC/IR/MAR/MBR/AC and sequences the registered-read memory and combinational ALU.
module accumulator_control_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [15:0] mem_rdata_i,
  output logic [3:0]  alu_opcode_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  input  logic [15:0] alu_result_i,
  output logic [15:0] pc_o,
  output logic [15:0] ir_o,
  output logic [15:0] acc_o,
  output logic        halted_o,
  output logic        illegal_o
);

  typedef enum logic [3:0] {
    StFetch0, StFetch1, StFetch2, StDecode, StRead, StLatch, StExec, StWrite, StHalt
  } state_e;

  localparam logic [3:0] OpLoad    = 4'h1;
  localparam logic [3:0] OpStore   = 4'h2;
  localparam logic [3:0] OpAdd     = 4'h3;
  localparam logic [3:0] OpSub     = 4'h4;
  localparam logic [3:0] OpAnd     = 4'h5;
  localparam logic [3:0] OpOr      = 4'h6;
  localparam logic [3:0] OpXor     = 4'h7;
  localparam logic [3:0] OpJump    = 4'h8;
  localparam logic [3:0] OpSkipz   = 4'h9;
  localparam logic [3:0] OpSkipneg = 4'hA;
  localparam logic [3:0] OpShl     = 4'hB;
  localparam logic [3:0] OpShr     = 4'hC;
  localparam logic [3:0] OpClear   = 4'hD;
  localparam logic [3:0] OpIllegal = 4'hE;
  localparam logic [3:0] OpHalt    = 4'hF;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;
  logic [15:0] ac_q, ac_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  opcode;
  logic [15:0] operand;
  logic [3:0]  alu_code;

  assign opcode  = ir_q[15:12];
  assign operand = {4'b0000, ir_q[11:0]};

  always_comb begin
    alu_code = 4'b0000;
    case (opcode)
      OpAdd:   alu_code = 4'b0000;
      OpSub:   alu_code = 4'b0001;
      OpAnd:   alu_code = 4'b1000;
      OpOr:    alu_code = 4'b1001;
      OpXor:   alu_code = 4'b1010;
      OpShl:   alu_code = 4'b0100;
      OpShr:   alu_code = 4'b0101;
      default: alu_code = 4'b0000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    mar_d        = mar_q;
    mbr_d        = mbr_q;
    ac_d         = ac_q;
    illegal_d    = illegal_q;
    alu_opcode_o = 4'b0000;

    unique case (state_q)
      StFetch0: begin
        if (run_i) begin
          mar_d   = pc_q;
          state_d = StFetch1;
        end
      end
      StFetch1: state_d = StFetch2;
      StFetch2: begin
        ir_d    = mem_rdata_i;
        pc_d    = pc_q + 16'd1;
        state_d = StDecode;
      end
      StDecode: begin
        alu_opcode_o = alu_code;
        mar_d        = operand;
        state_d      = StFetch0;
        case (opcode)
          OpLoad, OpAdd, OpSub, OpAnd, OpOr, OpXor: state_d = StRead;
          OpStore:   state_d = StWrite;
          OpJump:    pc_d = operand;
          // Skip increments on top of the fetch increment already in pc_q.
          OpSkipz:   if (ac_q == 16'h0000) pc_d = pc_q + 16'd1;
          OpSkipneg: if (ac_q[15]) pc_d = pc_q + 16'd1;
          OpShl, OpShr: ac_d = alu_result_i;
          OpClear:   ac_d = 16'h0000;
          OpIllegal: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
          OpHalt:    state_d = StHalt;
          default:   state_d = StFetch0;
        endcase
      end
      StRead:  state_d = StLatch;
      StLatch: begin
        mbr_d   = mem_rdata_i;
        state_d = StExec;
      end
      StExec: begin
        alu_opcode_o = alu_code;
        ac_d         = (opcode == OpLoad) ? mbr_q : alu_result_i;
        state_d      = StFetch0;
      end
      StWrite: state_d = StFetch0;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StFetch0;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      mar_q     <= 16'h0000;
      mbr_q     <= 16'h0000;
      ac_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset gates the strobe combinationally so an aborted STORE never reaches memory.
  assign mem_we_o    = (state_q == StWrite) && !reset_i;
  assign mem_addr_o  = mar_q;
  assign mem_wdata_o = ac_q;
  assign alu_a_o     = ac_q;
  assign alu_b_o     = mbr_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign acc_o       = ac_q;
  assign halted_o    = (state_q == StHalt);
  assign illegal_o   = illegal_q;

endmodule
